// File: rtl/dac_ab_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : dac_ab_scheduler
//  Description : Two-channel (A/B) sample scheduler for a dual parallel DAC
//                with a shared data bus. Each channel has a one-deep holding
//                register fed by an AXI-Stream-like valid/ready handshake.
//                A 5-state write FSM (IDLE, SETUP, STROBE, RELEASE, DONE)
//                issues one DAC write per 5 clocks. Ties between two full
//                channels are resolved round-robin; A wins the first tie
//                after reset.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NDATA        DAC sample width in bits (default 12)
//  Ports
//    clk          system clock, all logic on the rising edge
//    rst          asynchronous active-low reset
//    en           1 = new DAC writes may start; 0 = no new write starts
//    s_a_tvalid   channel A sample valid
//    s_a_tready   channel A can accept a sample (holding register empty)
//    s_a_tdata    channel A sample, bits [NDATA-1:0] used
//    s_b_*        channel B, same rules as channel A
//    dac_ab_sel   DAC channel select, 1 = DAC A, 0 = DAC B
//    da_cs_n      DAC chip select, active low
//    da_wr_n      DAC write strobe, active low (DAC latches on rising edge)
//    da_data      DAC parallel data bus
//    busy         1 while a write transaction is in progress
//  Configuration macro
//    DAC_OFFSET_BINARY_EN  when defined, da_data carries the held sample
//                          with its MSB inverted (two's complement to
//                          offset binary); otherwise the sample unchanged.
// ============================================================================
module dac_ab_scheduler #(
    parameter int NDATA = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             s_a_tvalid,
    output logic             s_a_tready,
    input  logic [31:0]      s_a_tdata,
    input  logic             s_b_tvalid,
    output logic             s_b_tready,
    input  logic [31:0]      s_b_tdata,
    output logic             dac_ab_sel,
    output logic             da_cs_n,
    output logic             da_wr_n,
    output logic [NDATA-1:0] da_data,
    output logic             busy
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_setup   = 3'd1;
    localparam logic [2:0] c_st_strobe  = 3'd2;
    localparam logic [2:0] c_st_release = 3'd3;
    localparam logic [2:0] c_st_done    = 3'd4;

`ifdef DAC_OFFSET_BINARY_EN
    // Flipping the MSB maps two's complement onto offset binary.
    localparam logic [NDATA-1:0] c_msb_mask = {1'b1, {(NDATA-1){1'b0}}};
`endif

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [2:0]       w_state_next;

    logic [NDATA-1:0] r_hold_a;
    logic [NDATA-1:0] r_hold_b;
    logic             r_full_a;
    logic             r_full_b;

    // r_grant_a doubles as the DAC select: it is only reloaded when a write
    // starts, so the select holds its last value while idle.
    logic             r_grant_a;
    // 1 = channel A was served by the most recent completed write.
    logic             r_last_a;
    logic [NDATA-1:0] r_data;

    logic             w_load_a;
    logic             w_load_b;
    logic             w_start;
    logic             w_done;
    logic             w_pick_a;
    logic [NDATA-1:0] w_pick_data;

    // ------------------------------------------------------------------------
    // Sample format conversion applied when a sample is moved onto the bus
    // register, so the reset value of the bus stays all-zero in both builds.
    // ------------------------------------------------------------------------
    function automatic logic [NDATA-1:0] f_to_dac(input logic [NDATA-1:0] x);
`ifdef DAC_OFFSET_BINARY_EN
        return x ^ c_msb_mask;
`else
        return x;
`endif
    endfunction

    // Upper tdata bits are deliberately ignored.
    generate
        if (NDATA < 32) begin : g_unused_tdata
            logic w_unused_tdata;
            assign w_unused_tdata = ^{s_a_tdata[31:NDATA], s_b_tdata[31:NDATA]};
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Handshake and control strobes
    // ------------------------------------------------------------------------
    // A full holding register is never overwritten; the granted channel stays
    // full until DONE, which freezes its register for the whole transaction.
    assign s_a_tready = ~r_full_a;
    assign s_b_tready = ~r_full_b;

    assign w_load_a = s_a_tvalid & ~r_full_a;
    assign w_load_b = s_b_tvalid & ~r_full_b;

    assign w_start = (r_state == c_st_idle) & en & (r_full_a | r_full_b);
    assign w_done  = (r_state == c_st_done);

    // Round-robin: a lone full channel wins; on a tie the channel that was
    // not served last wins.
    assign w_pick_a    = r_full_a & (~r_full_b | ~r_last_a);
    assign w_pick_data = w_pick_a ? r_hold_a : r_hold_b;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic. Once started, a write always runs to DONE; en
    // only gates the IDLE exit.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (en && (r_full_a || r_full_b)) begin
                    w_state_next = c_st_setup;
                end
            end
            c_st_setup:   w_state_next = c_st_strobe;
            c_st_strobe:  w_state_next = c_st_release;
            c_st_release: w_state_next = c_st_done;
            c_st_done:    w_state_next = c_st_idle;
            default:      w_state_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output decode. Strobes come straight from the state register so
    // that an asynchronous reset releases them immediately.
    // ------------------------------------------------------------------------
    always_comb begin
        da_cs_n = 1'b1;
        da_wr_n = 1'b1;
        busy    = 1'b0;
        case (r_state)
            c_st_setup: begin
                da_cs_n = 1'b0;
                busy    = 1'b1;
            end
            c_st_strobe: begin
                da_cs_n = 1'b0;
                da_wr_n = 1'b0;
                busy    = 1'b1;
            end
            c_st_release: begin
                // wr_n has risen; cs_n, select and data held for hold time.
                da_cs_n = 1'b0;
                busy    = 1'b1;
            end
            c_st_done: begin
                busy    = 1'b1;
            end
            default: begin
                da_cs_n = 1'b1;
                da_wr_n = 1'b1;
                busy    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Channel A holding register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_a <= '0;
            r_full_a <= 1'b0;
        end else begin
            if (w_load_a) begin
                r_hold_a <= s_a_tdata[NDATA-1:0];
                r_full_a <= 1'b1;
            end else if (w_done && r_grant_a) begin
                r_full_a <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Channel B holding register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_b <= '0;
            r_full_b <= 1'b0;
        end else begin
            if (w_load_b) begin
                r_hold_b <= s_b_tdata[NDATA-1:0];
                r_full_b <= 1'b1;
            end else if (w_done && !r_grant_a) begin
                r_full_b <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Grant, round-robin history and DAC bus registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant_a <= 1'b1;
            r_last_a  <= 1'b0;
            r_data    <= '0;
        end else begin
            if (w_start) begin
                r_grant_a <= w_pick_a;
                r_data    <= f_to_dac(w_pick_data);
            end
            if (w_done) begin
                r_last_a <= r_grant_a;
            end
        end
    end

    assign dac_ab_sel = r_grant_a;
    assign da_data    = r_data;

endmodule
`default_nettype wire

// File: tb/tb_dac_ab_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_ab_scheduler
//  Description : Self-checking bench for dac_ab_scheduler. Expected DAC
//                writes are queued when samples are driven; a negedge monitor
//                records every observed write and the main thread pops and
//                compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dac_ab_scheduler;

    localparam int NDATA = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             a_valid = 1'b0;
    logic             b_valid = 1'b0;
    logic [31:0]      a_data = '0;
    logic [31:0]      b_data = '0;
    logic             s_a_tready;
    logic             s_b_tready;
    logic             dac_ab_sel;
    logic             da_cs_n;
    logic             da_wr_n;
    logic [NDATA-1:0] da_data;
    logic             busy;

    dac_ab_scheduler #(.NDATA(NDATA)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .s_a_tvalid (a_valid),
        .s_a_tready (s_a_tready),
        .s_a_tdata  (a_data),
        .s_b_tvalid (b_valid),
        .s_b_tready (s_b_tready),
        .s_b_tdata  (b_data),
        .dac_ab_sel (dac_ab_sel),
        .da_cs_n    (da_cs_n),
        .da_wr_n    (da_wr_n),
        .da_data    (da_data),
        .busy       (busy)
    );

    always #31 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nwr = 0;
    int rd = 0;

    logic       obs_sel  [256];
    logic [11:0] obs_data [256];
    int         obs_cyc  [256];
    logic [12:0] exp_q [$];

    typedef struct {
        logic        va;
        logic [31:0] da;
        logic        vb;
        logic [31:0] db;
        int          n;
        logic        s0;
        logic [11:0] d0;
        logic        s1;
        logic [11:0] d1;
    } vec_t;

    vec_t tbl [5];

    always @(posedge clk) cyc <= cyc + 1;

    // One write observed per STROBE cycle.
    always @(negedge clk) begin
        if (rst && !da_wr_n) begin
            obs_sel[nwr[7:0]]  <= dac_ab_sel;
            obs_data[nwr[7:0]] <= da_data;
            obs_cyc[nwr[7:0]]  <= cyc;
            nwr <= nwr + 1;
        end
    end

    function automatic logic [11:0] exp_dac(input logic [11:0] x);
`ifdef DAC_OFFSET_BINARY_EN
        return {~x[11], x[10:0]};
`else
        return x;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic sel, input logic [11:0] d);
        exp_q.push_back({sel, exp_dac(d)});
    endtask

    // ch: 1 = channel A, 0 = channel B. Returns #1 after the accepting edge.
    task automatic send(input logic ch, input logic [31:0] d);
        logic r;
        r = 1'b0;
        if (ch) begin a_valid = 1'b1; a_data = d; end
        else    begin b_valid = 1'b1; b_data = d; end
        for (int t = 0; t < 400; t++) begin
            r = ch ? s_a_tready : s_b_tready;
            @(posedge clk);
            #1;
            if (r) break;
        end
        if (ch) a_valid = 1'b0;
        else    b_valid = 1'b0;
    endtask

    task automatic stream(input logic ch, input int n, input logic [11:0] base);
        for (int k = 0; k < n; k++) send(ch, {20'h0, base + 12'(k)});
    endtask

    task automatic process_obs();
        logic [12:0] e;
        while (rd != nwr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got write sel=%0d data=0x%0h, expected none",
                         obs_sel[rd[7:0]], obs_data[rd[7:0]]);
            end else begin
                e = exp_q.pop_front();
                check("sb_write", 32'({obs_sel[rd[7:0]], obs_data[rd[7:0]]}), 32'(e));
            end
            rd++;
        end
    endtask

    task automatic drain(input int maxc);
        for (int t = 0; t < maxc; t++) begin
            @(negedge clk);
            process_obs();
            if (exp_q.size() == 0 && !busy && rd == nwr) break;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic flag;

        tbl[0] = '{va:1'b1, da:32'h0000_07FF, vb:1'b0, db:32'h0,
                   n:1, s0:1'b1, d0:12'h7FF, s1:1'b0, d1:12'h000};
        tbl[1] = '{va:1'b0, da:32'h0, vb:1'b1, db:32'hABCD_E001,
                   n:1, s0:1'b0, d0:12'h001, s1:1'b0, d1:12'h000};
        tbl[2] = '{va:1'b1, da:32'h0000_0100, vb:1'b1, db:32'h0000_0200,
                   n:2, s0:1'b1, d0:12'h100, s1:1'b0, d1:12'h200};
        tbl[3] = '{va:1'b1, da:32'hFFFF_F800, vb:1'b1, db:32'h0000_0FFF,
                   n:2, s0:1'b1, d0:12'h800, s1:1'b0, d1:12'hFFF};
        tbl[4] = '{va:1'b1, da:32'h0000_0800, vb:1'b0, db:32'h0,
                   n:1, s0:1'b1, d0:12'h800, s1:1'b0, d1:12'h000};

        // Reset state
        do_reset();
        check("rst_sel",      32'(dac_ab_sel), 32'd1);
        check("rst_cs_n",     32'(da_cs_n),    32'd1);
        check("rst_wr_n",     32'(da_wr_n),    32'd1);
        check("rst_data",     32'(da_data),    32'd0);
        check("rst_busy",     32'(busy),       32'd0);
        check("rst_tready_a", 32'(s_a_tready), 32'd1);
        check("rst_tready_b", 32'(s_b_tready), 32'd1);

        // Single A write, phase by phase
        en = 1'b1;
        push(1'b1, 12'h7FF);
        send(1'b1, 32'h7FF);
        @(negedge clk);
        check("idle_tready_a", 32'(s_a_tready), 32'd0);
        check("idle_cs_n",     32'(da_cs_n),    32'd1);
        @(negedge clk);
        check("setup_sel",  32'(dac_ab_sel), 32'd1);
        check("setup_data", 32'(da_data),    32'(exp_dac(12'h7FF)));
        check("setup_cs_n", 32'(da_cs_n),    32'd0);
        check("setup_wr_n", 32'(da_wr_n),    32'd1);
        check("setup_busy", 32'(busy),       32'd1);
        @(negedge clk);
        check("strobe_wr_n", 32'(da_wr_n), 32'd0);
        check("strobe_cs_n", 32'(da_cs_n), 32'd0);
        @(negedge clk);
        check("release_wr_n", 32'(da_wr_n), 32'd1);
        check("release_cs_n", 32'(da_cs_n), 32'd0);
        check("release_data", 32'(da_data), 32'(exp_dac(12'h7FF)));
        @(negedge clk);
        check("done_cs_n", 32'(da_cs_n), 32'd1);
        check("done_busy", 32'(busy),    32'd1);
        @(negedge clk);
        check("after_tready_a", 32'(s_a_tready), 32'd1);
        check("after_busy",     32'(busy),       32'd0);
        check("idle_sel_hold",  32'(dac_ab_sel), 32'd1);
        check("idle_data_hold", 32'(da_data),    32'(exp_dac(12'h7FF)));
        drain(20);

        // Table-driven vectors, each from reset (A wins the first tie)
        for (int i = 0; i < 5; i++) begin
            do_reset();
            en = 1'b1;
            base = nwr;
            push(tbl[i].s0, tbl[i].d0);
            if (tbl[i].n == 2) push(tbl[i].s1, tbl[i].d1);
            fork
                begin if (tbl[i].va) send(1'b1, tbl[i].da); end
                begin if (tbl[i].vb) send(1'b0, tbl[i].db); end
            join
            drain(60);
            check("vec_nwrites", 32'(nwr - base), 32'(tbl[i].n));
            if (tbl[i].n == 2)
                check("vec_spacing", 32'(obs_cyc[8'(nwr - 1)] - obs_cyc[8'(nwr - 2)]), 32'd5);
        end

        // en low with both channels full: nothing starts
        do_reset();
        push(1'b1, 12'h111);
        push(1'b0, 12'h222);
        fork
            send(1'b1, 32'h111);
            send(1'b0, 32'h222);
        join
        flag = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (!da_cs_n) flag = 1'b1;
        end
        check("en0_no_cs",    32'(flag),       32'd0);
        check("en0_tready_a", 32'(s_a_tready), 32'd0);
        check("en0_tready_b", 32'(s_b_tready), 32'd0);
        base = nwr;
        en = 1'b1;
        drain(60);
        check("en1_nwrites", 32'(nwr - base), 32'd2);

        // Continuous traffic on both channels: strict alternation
        do_reset();
        en = 1'b1;
        base = nwr;
        for (int k = 0; k < 10; k++) begin
            push(1'b1, 12'h300 + 12'(k));
            push(1'b0, 12'hC00 + 12'(k));
        end
        fork
            stream(1'b1, 10, 12'h300);
            stream(1'b0, 10, 12'hC00);
        join
        drain(200);
        check("alt_nwrites", 32'(nwr - base), 32'd20);

        // Reset asserted during STROBE
        do_reset();
        en = 1'b1;
        push(1'b1, 12'h555);
        send(1'b1, 32'h555);
        flag = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (!da_wr_n) begin
                flag = 1'b1;
                break;
            end
        end
        check("rst_reached_strobe", 32'(flag), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midrst_wr_n", 32'(da_wr_n), 32'd1);
        check("midrst_cs_n", 32'(da_cs_n), 32'd1);
        check("midrst_busy", 32'(busy),    32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_tready_a", 32'(s_a_tready), 32'd1);
        check("midrst_tready_b", 32'(s_b_tready), 32'd1);
        drain(20);
        base = nwr;
        repeat (10) @(negedge clk);
        check("midrst_discard", 32'(nwr - base), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dac_ab_scheduler.md
DAC_AB_SCHEDULER -- requirements
Module: dac_ab_scheduler

Interface
REQ-001 Parameter NDATA, default 12: DAC sample width in bits.
REQ-002 clk  input  1  system clock, 16 MHz; one clock domain; all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  when 1, scheduler may start DAC writes; when 0, no new write starts.
REQ-005 s_a_tvalid  input  1  channel A sample valid.
REQ-006 s_a_tready  output  1  channel A can accept a sample.
REQ-007 s_a_tdata  input  32  channel A sample; bits [NDATA-1:0] used, rest ignored.
REQ-008 s_b_tvalid / s_b_tready / s_b_tdata  in/out/in  1/1/32  channel B, same rules as A.
REQ-009 dac_ab_sel  output  1  DAC channel select; 1 = DAC A, 0 = DAC B.
REQ-010 da_cs_n  output  1  DAC chip select, active low.
REQ-011 da_wr_n  output  1  DAC write strobe, active low; DAC latches on the rising edge.
REQ-012 da_data  output  NDATA  DAC parallel data bus.
REQ-013 busy  output  1  1 while a write transaction is in progress (any state except IDLE).

Function
REQ-014 Each channel SHALL have one holding register plus a full flag; s_x_tready = !full_x (combinational).
REQ-015 A sample is accepted when s_x_tvalid && s_x_tready on a rising edge; register loads [NDATA-1:0] and full_x goes 1.
REQ-016 FSM states: IDLE, SETUP, STROBE, RELEASE, DONE; each non-IDLE state lasts exactly 1 cycle; one write = 4 cycles.
REQ-017 IDLE -> SETUP when en=1 and (full_a or full_b); otherwise stay in IDLE.
REQ-018 Grant in IDLE: only one full -> that channel; both full -> channel not served last (round-robin); last_served resets to B, so A wins the first tie.
REQ-019 SETUP: dac_ab_sel = granted channel, da_data = its register value, da_cs_n = 0, da_wr_n = 1.
REQ-020 STROBE: da_wr_n = 0; dac_ab_sel, da_data, da_cs_n held.
REQ-021 RELEASE: da_wr_n = 1; data and select held (hold time after rising edge of wr_n).
REQ-022 DONE: da_cs_n = 1; granted channel's full flag cleared; last_served updated; next state IDLE.
REQ-023 Granted channel's register SHALL NOT change from SETUP through DONE (its tready is 0 while full).
REQ-024 Non-granted channel may accept a sample at any time while its full flag is 0.
REQ-025 A channel cleared in DONE reads tready = 1 the next cycle; load and clear never coincide on the same channel.
REQ-026 dac_ab_sel and da_data SHALL keep their last values in IDLE (no glitch between writes).
REQ-027 en falling during a transaction SHALL NOT abort it; FSM completes through DONE, then waits in IDLE.
REQ-028 Maximum throughput: one write per 5 cycles (4 states plus IDLE); back-to-back A/B alternation when both channels keep data ready.

Reset
REQ-029 On rst = 0, asynchronously: FSM = IDLE, full_a = full_b = 0, last_served = B, dac_ab_sel = 1, da_cs_n = 1, da_wr_n = 1, da_data = 0, busy = 0.
REQ-030 Reset asserted mid-transaction SHALL immediately return da_cs_n and da_wr_n to 1 and discard both held samples.
REQ-031 After reset release, s_a_tready = s_b_tready = 1.

Configuration
REQ-032 Macro DAC_OFFSET_BINARY_EN: when defined, da_data = held sample with MSB inverted (two's complement to offset binary); when undefined, da_data = held sample unchanged.

Verification
REQ-033 Reset: rst=0 during STROBE -> da_wr_n=1, da_cs_n=1, busy=0 asynchronously; both tready=1 after release.
REQ-034 Single A sample 0x7FF, en=1 -> SETUP sel=1 data=0x7FF cs_n=0; STROBE wr_n=0; RELEASE wr_n=1; DONE cs_n=1; s_a_tready=1 next cycle.
REQ-035 A=0x100 and B=0x200 accepted same cycle -> A written first, then B; sel 1 then 0; writes 5 cycles apart.
REQ-036 Continuous A and B valid for 20 writes -> strict alternation A,B,A,B; no sample lost or duplicated.
REQ-037 en=0 with both channels full -> no cs_n activity, both tready=0; en=1 -> writes resume, A first after reset.
REQ-038 DAC_OFFSET_BINARY_EN defined, sample 0x800 -> da_data=0x000; undefined -> da_data=0x800.
